// File: rtl/jtexterm_obj_scan.sv
// Per-line object scanner/drawer: walks the object table in VRAM, fetches 16x16 4bpp rows
// from ROM and writes opaque pixels into the line buffer. Optional macro: JTEXTERM_OBJ_ENDMARK_EN.
module jtexterm_obj_scan #(
  parameter logic [12:0] OBJ_BASE = 13'h1800,
  parameter int          OBJ_MAX  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs,
  input  logic [8:0]  vdump,
  output logic [12:0] scan_addr,
  input  logic [7:0]  scan_dout,
  output logic        rom_cs,
  output logic [19:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        rom_ok,
  output logic [8:0]  line_addr,
  output logic [8:0]  line_din,
  output logic        line_we,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, RD0, RD1, RD2, RD3, CHECK, FETCH, DRAW, NEXT
  } state_t;

  state_t      state, state_next;
  logic        hs_l;
  logic        hs_edge;
  logic [7:0]  n;
  logic [7:0]  obj_y, code_lo, attr, x_lo;
  logic [3:0]  ysub;
  logic        half;
  logic        fetch_first;
  logic [2:0]  p;
  logic [31:0] rom_word;

  logic        hflip;
  logic [3:0]  pal;
  logic [8:0]  obj_x;
  logic [9:0]  code;
  logic [8:0]  ydiff;
  logic        hit;
  logic        last_obj;
  logic        end_mark;
  logic [2:0]  nib_sel;
  logic [3:0]  pix;

  assign hs_edge  = hs & ~hs_l;
  assign hflip    = attr[3];
  assign pal      = attr[7:4];
  assign obj_x    = {attr[2], x_lo};
  assign code     = {attr[1:0], code_lo};
  assign ydiff    = vdump + 9'd1 - {1'b0, obj_y};
  assign hit      = (ydiff[8:4] == 5'd0);
  assign last_obj = (({1'b0, n} + 9'd1) == 9'(OBJ_MAX));
  // ~p is 7-p for a 3-bit index: leftmost pixel lives in the top nibble
  assign nib_sel  = hflip ? p : ~p;
  assign pix      = 4'(rom_word >> {nib_sel, 2'b00});
  assign busy     = (state != IDLE);

`ifdef JTEXTERM_OBJ_ENDMARK_EN
  assign end_mark = (obj_y == 8'hFF);
`else
  assign end_mark = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    scan_addr  = 13'd0;
    rom_cs     = 1'b0;
    rom_addr   = 20'd0;
    line_addr  = 9'd0;
    line_din   = 9'd0;
    line_we    = 1'b0;
    case (state)
      IDLE: ;
      RD0: begin
        scan_addr  = OBJ_BASE + {3'd0, n, 2'd0};
        state_next = RD1;
      end
      RD1: begin
        scan_addr  = OBJ_BASE + {3'd0, n, 2'd1};
        state_next = RD2;
      end
      RD2: begin
        scan_addr  = OBJ_BASE + {3'd0, n, 2'd2};
        state_next = RD3;
      end
      RD3: begin
        scan_addr  = OBJ_BASE + {3'd0, n, 2'd3};
        state_next = CHECK;
      end
      CHECK: begin
        if (end_mark) state_next = IDLE;
        else if (hit) state_next = FETCH;
        else          state_next = NEXT;
      end
      FETCH: begin
        rom_cs   = 1'b1;
        rom_addr = {5'd0, code, ysub, half ^ hflip};
        // rom_ok may still be high from the previous address on the first cycle
        if (!fetch_first && rom_ok) state_next = DRAW;
      end
      DRAW: begin
        line_addr = obj_x + {5'd0, half, p};
        line_din  = {1'b0, pal, pix};
        line_we   = (pix != 4'd0);
        if (p == 3'd7) state_next = half ? NEXT : FETCH;
      end
      NEXT: begin
        state_next = last_obj ? IDLE : RD0;
      end
      default: state_next = IDLE;
    endcase
    // a new sync always wins, cutting off any write or fetch in flight
    if (hs_edge) begin
      state_next = RD0;
      rom_cs     = 1'b0;
      line_we    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_l        <= 1'b0;
      n           <= 8'd0;
      obj_y       <= 8'd0;
      code_lo     <= 8'd0;
      attr        <= 8'd0;
      x_lo        <= 8'd0;
      ysub        <= 4'd0;
      half        <= 1'b0;
      fetch_first <= 1'b0;
      p           <= 3'd0;
      rom_word    <= 32'd0;
    end else begin
      hs_l        <= hs;
      fetch_first <= (state != FETCH);
      p           <= (state == DRAW) ? p + 3'd1 : 3'd0;
      case (state)
        RD1:   obj_y   <= scan_dout;
        RD2:   code_lo <= scan_dout;
        RD3:   attr    <= scan_dout;
        CHECK: begin
          x_lo <= scan_dout;
          ysub <= ydiff[3:0];
          half <= 1'b0;
        end
        FETCH: if (!fetch_first && rom_ok) rom_word <= rom_data;
        DRAW:  if (p == 3'd7) half <= 1'b1;
        NEXT:  n <= last_obj ? 8'd0 : n + 8'd1;
        default: ;
      endcase
      if (hs_edge || (state == CHECK && end_mark)) n <= 8'd0;
    end
  end

endmodule

// File: tb/tb_jtexterm_obj_scan.sv
// Directed bench for jtexterm_obj_scan: VRAM and ROM models, write/fetch logging, one task per scenario.
module tb_jtexterm_obj_scan;

  logic        clk;
  logic        rst;
  logic        hs;
  logic [8:0]  vdump;
  logic [12:0] scan_addr;
  logic [7:0]  scan_dout;
  logic        rom_cs;
  logic [19:0] rom_addr;
  logic [31:0] rom_data;
  logic        rom_ok;
  logic [8:0]  line_addr;
  logic [8:0]  line_din;
  logic        line_we;
  logic        busy;

  int checks = 0;
  int errors = 0;

  jtexterm_obj_scan #(.OBJ_BASE(13'h1800), .OBJ_MAX(64)) dut (
    .clk(clk), .rst(rst), .hs(hs), .vdump(vdump),
    .scan_addr(scan_addr), .scan_dout(scan_dout),
    .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
    .line_addr(line_addr), .line_din(line_din), .line_we(line_we), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM scan port: registered read
  logic [7:0] vram [0:8191];
  always @(posedge clk) scan_dout <= vram[scan_addr];

  // ROM: rom_ok rises on the 4th cycle of a stable request
  logic [19:0] rom_last;
  int          rom_cnt;
  always @(posedge clk) begin
    rom_last <= rom_addr;
    if (!rom_cs || rom_addr != rom_last) rom_cnt <= 0;
    else                                 rom_cnt <= rom_cnt + 1;
  end
  assign rom_ok = rom_cs && (rom_addr == rom_last) && (rom_cnt >= 2);

  // Logs sampled on the falling edge
  logic [8:0]  wr_addr_q [$];
  logic [8:0]  wr_din_q  [$];
  logic [19:0] fetch_q   [$];
  logic [12:0] scan_q    [$];
  logic        cs_prev;
  logic [19:0] addr_prev;
  always @(negedge clk) begin
    if (line_we) begin
      wr_addr_q.push_back(line_addr);
      wr_din_q.push_back(line_din);
    end
    if (rom_cs && (!cs_prev || rom_addr != addr_prev)) fetch_q.push_back(rom_addr);
    if (busy) scan_q.push_back(scan_addr);
    cs_prev   <= rom_cs;
    addr_prev <= rom_addr;
  end

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_din_q.delete();
    fetch_q.delete();
    scan_q.delete();
  endtask

  task automatic init_table();
    for (int i = 0; i < 64; i++) begin
      vram[32'h1800 + 4*i]     = 8'h80;
      vram[32'h1800 + 4*i + 1] = 8'h00;
      vram[32'h1800 + 4*i + 2] = 8'h00;
      vram[32'h1800 + 4*i + 3] = 8'h00;
    end
  endtask

  task automatic set_obj(input int idx, input logic [7:0] y, input logic [9:0] code,
                         input logic [3:0] pal, input logic hf, input logic [8:0] x);
    int base;
    base = 32'h1800 + 4*idx;
    vram[base]     = y;
    vram[base + 1] = code[7:0];
    vram[base + 2] = {pal, hf, x[8], code[9:8]};
    vram[base + 3] = x[7:0];
  endtask

  // cyc counts rising edges from the one that sees the hs edge until busy is seen low
  task automatic run_line(input logic [8:0] vd, input int budget, output int cyc);
    vdump = vd;
    clear_logs();
    @(negedge clk); hs = 1'b1;
    @(negedge clk); hs = 1'b0;
    cyc = 1;
    while (busy && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL line_timeout busy still high after %0d cycles", cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; hs = 1'b0; vdump = 9'd0; rom_data = 32'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rom_cs, line_we, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got cs/we/busy=%b want 000", {rom_cs, line_we, busy});
    end
    checks++;
    if (scan_addr !== 13'd0 || rom_addr !== 20'd0) begin
      errors++; $display("FAIL reset_addr got scan=%h rom=%h want 0", scan_addr, rom_addr);
    end
    checks++;
    if (line_addr !== 9'd0 || line_din !== 9'd0) begin
      errors++; $display("FAIL reset_line got addr=%h din=%h want 0", line_addr, line_din);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("reset done");
  endtask

  task automatic test_single();
    int cyc;
    init_table();
    set_obj(0, 8'h20, 10'h005, 4'h3, 1'b0, 9'h040);
    rom_data = 32'h1234_5678;
    run_line(9'h024, 1000, cyc);
    checks++;
    if (fetch_q.size() != 2 || fetch_q[0] !== 20'h000AA || fetch_q[1] !== 20'h000AB) begin
      errors++; $display("FAIL single_fetch got n=%0d first=%h want 2 000AA/000AB",
                         fetch_q.size(), fetch_q.size() > 0 ? fetch_q[0] : 20'h0);
    end
    checks++;
    if (wr_addr_q.size() != 16) begin
      errors++; $display("FAIL single_count got %0d writes want 16", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (wr_addr_q[i] !== 9'h040 + 9'(i) || wr_din_q[i] !== 9'h030 + 9'(i % 8 + 1)) begin
          errors++; $display("FAIL single_pix%0d got %h/%h want %h/%h", i, wr_addr_q[i], wr_din_q[i],
                             9'h040 + 9'(i), 9'h030 + 9'(i % 8 + 1));
        end
      end
    end
    checks++;
    if (cyc != 409) begin
      errors++; $display("FAIL single_cycles got %0d want 409", cyc);
    end
    $display("single: fetches=%0d writes=%0d cycles=%0d", fetch_q.size(), wr_addr_q.size(), cyc);
  endtask

  task automatic test_hflip();
    int cyc;
    logic [8:0] ea [4];
    logic [8:0] ed [4];
    ea = '{9'h045, 9'h047, 9'h04D, 9'h04F};
    ed = '{9'h033, 9'h031, 9'h033, 9'h031};
    init_table();
    set_obj(0, 8'h20, 10'h005, 4'h3, 1'b1, 9'h040);
    rom_data = 32'h1030_0000;
    run_line(9'h024, 1000, cyc);
    checks++;
    if (fetch_q.size() != 2 || fetch_q[0] !== 20'h000AB || fetch_q[1] !== 20'h000AA) begin
      errors++; $display("FAIL hflip_fetch got n=%0d first=%h want 2 000AB/000AA",
                         fetch_q.size(), fetch_q.size() > 0 ? fetch_q[0] : 20'h0);
    end
    checks++;
    if (wr_addr_q.size() != 4) begin
      errors++; $display("FAIL hflip_count got %0d writes want 4", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_addr_q[i] !== ea[i] || wr_din_q[i] !== ed[i]) begin
          errors++; $display("FAIL hflip_pix%0d got %h/%h want %h/%h", i, wr_addr_q[i], wr_din_q[i], ea[i], ed[i]);
        end
      end
    end
    $display("hflip: fetches=%0d writes=%0d", fetch_q.size(), wr_addr_q.size());
  endtask

  task automatic test_miss();
    int cyc;
    init_table();
    set_obj(0, 8'h20, 10'h005, 4'h3, 1'b0, 9'h040);
    rom_data = 32'h1234_5678;
    run_line(9'h040, 1000, cyc);
    checks++;
    if (fetch_q.size() != 0 || wr_addr_q.size() != 0) begin
      errors++; $display("FAIL miss_activity got fetches=%0d writes=%0d want 0/0", fetch_q.size(), wr_addr_q.size());
    end
    checks++;
    if (cyc != 385) begin
      errors++; $display("FAIL miss_cycles got %0d want 385", cyc);
    end
    $display("miss: cycles=%0d", cyc);
  endtask

  task automatic test_wrap();
    int cyc;
    init_table();
    set_obj(0, 8'h20, 10'h005, 4'h3, 1'b0, 9'h1FC);
    rom_data = 32'h1234_5678;
    run_line(9'h024, 1000, cyc);
    checks++;
    if (wr_addr_q.size() != 16 || wr_addr_q[0] !== 9'h1FC || wr_addr_q[3] !== 9'h1FF ||
        wr_addr_q[4] !== 9'h000 || wr_addr_q[15] !== 9'h00B) begin
      errors++; $display("FAIL wrap_x got n=%0d first=%h want 16 1FC..1FF,000..00B",
                         wr_addr_q.size(), wr_addr_q.size() > 0 ? wr_addr_q[0] : 9'h0);
    end
    $display("wrap_x: writes=%0d", wr_addr_q.size());

    init_table();
    set_obj(0, 8'hF8, 10'h005, 4'h3, 1'b0, 9'h040);
    run_line(9'h102, 1000, cyc);
    checks++;
    if (fetch_q.size() != 2 || fetch_q[0] !== 20'h000B6 || wr_addr_q.size() != 16) begin
      errors++; $display("FAIL wrap_y got fetches=%0d first=%h writes=%0d want 2 000B6 16",
                         fetch_q.size(), fetch_q.size() > 0 ? fetch_q[0] : 20'h0, wr_addr_q.size());
    end
    $display("wrap_y: fetches=%0d writes=%0d", fetch_q.size(), wr_addr_q.size());

    init_table();
    set_obj(0, 8'h00, 10'h005, 4'h3, 1'b0, 9'h040);
    run_line(9'h1FF, 1000, cyc);
    checks++;
    if (fetch_q.size() != 2 || fetch_q[0] !== 20'h000A0) begin
      errors++; $display("FAIL wrap_vdump got fetches=%0d first=%h want 2 000A0",
                         fetch_q.size(), fetch_q.size() > 0 ? fetch_q[0] : 20'h0);
    end
    $display("wrap_vdump: fetches=%0d", fetch_q.size());
  endtask

  task automatic test_abort();
    int guard;
    init_table();
    set_obj(3, 8'h20, 10'h005, 4'h3, 1'b0, 9'h040);
    rom_data = 32'h1234_5678;
    vdump = 9'h024;
    clear_logs();
    @(negedge clk); hs = 1'b1;
    @(negedge clk); hs = 1'b0;
    guard = 0;
    while (!line_we && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (!line_we) begin
      errors++; $display("FAIL abort_draw got no line_we within %0d cycles", guard);
    end
    #2 hs = 1'b1;
    #1;
    checks++;
    if (line_we !== 1'b0 || rom_cs !== 1'b0) begin
      errors++; $display("FAIL abort_we got we=%b cs=%b want 0/0", line_we, rom_cs);
    end
    @(negedge clk);
    checks++;
    if (scan_addr !== 13'h1800 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_restart got scan=%h busy=%b want 1800/1", scan_addr, busy);
    end
    hs = 1'b0;
    guard = 0;
    while (busy && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (busy || wr_addr_q.size() != 17) begin
      errors++; $display("FAIL abort_total got busy=%b writes=%0d want 0/17", busy, wr_addr_q.size());
    end
    $display("abort: writes=%0d", wr_addr_q.size());
  endtask

  task automatic test_reset_mid_fetch();
    int guard;
    init_table();
    set_obj(0, 8'h20, 10'h005, 4'h3, 1'b0, 9'h040);
    rom_data = 32'h1234_5678;
    vdump = 9'h024;
    clear_logs();
    @(negedge clk); hs = 1'b1;
    @(negedge clk); hs = 1'b0;
    guard = 0;
    while (!rom_cs && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rom_cs, line_we, busy} !== 3'b000 || rom_addr !== 20'd0) begin
      errors++; $display("FAIL rst_async got cs/we/busy=%b rom_addr=%h want 000/0",
                         {rom_cs, line_we, busy}, rom_addr);
    end
    @(negedge clk); rst = 1'b0;
    repeat (50) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wr_addr_q.size() != 0) begin
      errors++; $display("FAIL rst_quiet got busy=%b writes=%0d want 0/0", busy, wr_addr_q.size());
    end
    $display("reset_mid_fetch: writes=%0d", wr_addr_q.size());
  endtask

  task automatic test_endmark();
    int cyc;
    logic [12:0] max_scan;
    init_table();
    vram[32'h1800 + 8] = 8'hFF;
    set_obj(4, 8'h20, 10'h005, 4'h3, 1'b0, 9'h040);
    rom_data = 32'h1234_5678;
    run_line(9'h024, 1000, cyc);
    max_scan = 13'd0;
    foreach (scan_q[i]) if (scan_q[i] > max_scan) max_scan = scan_q[i];
`ifdef JTEXTERM_OBJ_ENDMARK_EN
    checks++;
    if (cyc != 18 || max_scan > 13'h180B || wr_addr_q.size() != 0) begin
      errors++; $display("FAIL endmark_on got cyc=%0d max_scan=%h writes=%0d want 18 <=180B 0",
                         cyc, max_scan, wr_addr_q.size());
    end
`else
    checks++;
    if (cyc != 409 || max_scan !== 13'h18FF || wr_addr_q.size() != 16) begin
      errors++; $display("FAIL endmark_off got cyc=%0d max_scan=%h writes=%0d want 409 18FF 16",
                         cyc, max_scan, wr_addr_q.size());
    end
`endif
    $display("endmark: cycles=%0d max_scan=%h writes=%0d", cyc, max_scan, wr_addr_q.size());
  endtask

  initial begin
    test_reset();
    test_single();
    test_hflip();
    test_miss();
    test_wrap();
    test_abort();
    test_reset_mid_fetch();
    test_endmark();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
